spi: RTL and testbench



---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_if.sv | 27 ++
 rtl/spi_sync.sv | 29 ++
 rtl/spi.sv | 134 +++++++++++++
 tb/tb_spi.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared widths, types and the transmit-queue state encoding for the SPI slave.
package spi_pkg;

  localparam int SPI_BYTE_W     = 8;
  localparam int SPI_SYNC_DEPTH = 3;
  localparam int SPI_CNT_W      = $clog2(SPI_BYTE_W);

  typedef logic [SPI_CNT_W-1:0]  bit_count_t;
  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_PEND   = 2'd1,
    TX_ACTIVE = 2'd2
  } tx_state_t;

  localparam bit_count_t BIT_LAST = bit_count_t'(SPI_BYTE_W - 1);

  function automatic spi_byte_t shift_in(input spi_byte_t cur, input logic bit_in);
    return {cur[SPI_BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_if.sv
// Serial pins plus the parallel byte handshake of the SPI slave, with
// master (bench/host) and slave (spi block) views.
interface spi_if;
  import spi_pkg::*;

  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       SSEL;
  logic       data_ready;
  spi_byte_t  data_recv;
  spi_byte_t  data_send;
  logic       do_send;
  bit_count_t bit_count_out;
  logic       busy;

  modport slave (
    input  SCK, MOSI, SSEL, data_send, do_send,
    output MISO, data_ready, data_recv, bit_count_out, busy
  );

  modport master (
    output SCK, MOSI, SSEL, data_send, do_send,
    input  MISO, data_ready, data_recv, bit_count_out, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input with edge detection
// taken from the two oldest stages.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SPI_SYNC_DEPTH{RST_VAL}};
    else     sync_q <= {sync_q[SPI_SYNC_DEPTH-2:0], din};
  end

  // level is taken from the same stage as the newer edge sample so that
  // data and edge strobes stay aligned
  assign level = sync_q[SPI_SYNC_DEPTH-2];
  assign rise  =  sync_q[SPI_SYNC_DEPTH-2] & ~sync_q[SPI_SYNC_DEPTH-1];
  assign fall  = ~sync_q[SPI_SYNC_DEPTH-2] &  sync_q[SPI_SYNC_DEPTH-1];

endmodule

// File: rtl/spi.sv
// SPI mode-0 slave, MSB first, oversampled on clk with a one-byte transmit queue.
// Build option: SPI_MISO_TRISTATE_EN releases MISO to Z while deselected.
//
// state     | meaning
// TX_IDLE   | no queued byte; byte boundaries load 0x00
// TX_PEND   | byte captured from data_send, waiting for the next boundary
// TX_ACTIVE | queued byte loaded and shifting out; ends with its data_ready
module spi
  import spi_pkg::*;
(
  input logic  clk,
  input logic  rst,
  spi_if.slave bus
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic ssel_level, ssel_fall, ssel_rise_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SCK),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_ssel (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SSEL),
    .level (ssel_level),
    .rise  (ssel_rise_unused),
    .fall  (ssel_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.MOSI),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  tx_state_t  state_q, state_d;
  bit_count_t bit_count;
  spi_byte_t  rx_shift;
  spi_byte_t  data_recv_q;
  logic       data_ready_q;
  spi_byte_t  tx_shift;
  spi_byte_t  pend_byte;

  logic ssel_active;
  logic byte_done;
  logic boundary;
  logic busy;
  logic send_accept;

  assign ssel_active = ~ssel_level;
  assign byte_done   = ssel_active & sck_rise & (bit_count == BIT_LAST);
  // after the 8th rising edge the counter has wrapped, so a falling edge
  // seen at count 0 inside a frame is always an inter-byte boundary
  assign boundary    = ssel_fall | (ssel_active & sck_fall & (bit_count == '0));
  assign busy        = (state_q != TX_IDLE);
  assign send_accept = bus.do_send & ~busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count    <= '0;
      rx_shift     <= '0;
      data_recv_q  <= '0;
      data_ready_q <= 1'b0;
    end else begin
      data_ready_q <= byte_done;
      if (!ssel_active) begin
        bit_count <= '0;
        rx_shift  <= '0;
      end else if (sck_rise) begin
        bit_count <= bit_count + 1'b1;
        rx_shift  <= shift_in(rx_shift, mosi_level);
      end
      if (byte_done) data_recv_q <= shift_in(rx_shift, mosi_level);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift  <= '0;
      pend_byte <= '0;
    end else begin
      if (send_accept)
        pend_byte <= bus.data_send;
      else if (boundary && state_q == TX_PEND)
        pend_byte <= '0;

      if (!ssel_active)
        tx_shift <= '0;
      else if (boundary)
        tx_shift <= (state_q == TX_PEND) ? pend_byte : '0;
      else if (sck_fall)
        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:   if (send_accept) state_d = TX_PEND;
      TX_PEND:   if (boundary)    state_d = TX_ACTIVE;
      // deselect mid-byte drops the loaded byte; a byte still in TX_PEND survives
      TX_ACTIVE: if (!ssel_active || data_ready_q) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  assign bus.data_ready    = data_ready_q;
  assign bus.data_recv     = data_recv_q;
  assign bus.bit_count_out = bit_count;
  assign bus.busy          = busy;

`ifdef SPI_MISO_TRISTATE_EN
  assign bus.MISO = ssel_level ? 1'bz : tx_shift[SPI_BYTE_W-1];
`else
  assign bus.MISO = ssel_level ? 1'b0 : tx_shift[SPI_BYTE_W-1];
`endif

endmodule

// File: tb/tb_spi.sv
// Directed bench for the SPI slave: single-byte frame table plus hand-written
// multi-byte, handshake, abort and reset sequences.
module tb_spi;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst;

  spi_if spi_bus ();

  spi dut (
    .clk (clk),
    .rst (rst),
    .bus (spi_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // data_ready monitor: record each pulse's byte, busy during it, busy one clk later
  spi_byte_t rx_q[$];
  logic      rdy_busy_q[$];
  logic      post_busy_q[$];
  logic      rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (rdy_prev) post_busy_q.push_back(spi_bus.busy);
    if (spi_bus.data_ready === 1'b1) begin
      rx_q.push_back(spi_bus.data_recv);
      rdy_busy_q.push_back(spi_bus.busy);
    end
    rdy_prev = (spi_bus.data_ready === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rdy_busy_q.delete();
    post_busy_q.delete();
  endtask

  task automatic xfer_bits(input spi_byte_t mosi, input int nbits, output spi_byte_t miso);
    spi_byte_t m;
    m = mosi;
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.MOSI = m[SPI_BYTE_W-1];
      m = m << 1;
      tick(HALF);
      miso = {miso[SPI_BYTE_W-2:0], spi_bus.MISO};
      spi_bus.SCK = 1'b1;
      tick(HALF);
      spi_bus.SCK = 1'b0;
    end
    if (nbits < SPI_BYTE_W) miso = miso << (SPI_BYTE_W - nbits);
  endtask

  task automatic frame_start();
    spi_bus.SSEL = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    tick(HALF);
    spi_bus.SSEL = 1'b1;
    tick(8);
  endtask

  task automatic queue_send(input spi_byte_t b);
    check("busy_before_send", 32'(spi_bus.busy), 32'd0);
    spi_bus.data_send = b;
    spi_bus.do_send   = 1'b1;
    tick(1);
    spi_bus.do_send   = 1'b0;
    check("busy_rise", 32'(spi_bus.busy), 32'd1);
  endtask

  typedef struct {
    bit        queue;
    spi_byte_t send;
    spi_byte_t mosi;
    spi_byte_t exp_recv;
    spi_byte_t exp_miso;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_byte_t rd, r0, r1, r2;
    int budget;

    vecs[0] = '{1'b0, 8'h00, 8'hA5, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 8'hDE, 8'h00, 8'h00, 8'hDE};
    vecs[2] = '{1'b1, 8'h81, 8'hFF, 8'hFF, 8'h81};
    vecs[3] = '{1'b0, 8'h00, 8'h5A, 8'h5A, 8'h00};

    rst               = 1'b1;
    spi_bus.SCK       = 1'b0;
    spi_bus.MOSI      = 1'b0;
    spi_bus.SSEL      = 1'b1;
    spi_bus.do_send   = 1'b0;
    spi_bus.data_send = '0;
    tick(3);
    check("rst_data_ready", 32'(spi_bus.data_ready), 32'd0);
    check("rst_data_recv", 32'(spi_bus.data_recv), 32'd0);
    check("rst_bit_count", 32'(spi_bus.bit_count_out), 32'd0);
    check("rst_busy", 32'(spi_bus.busy), 32'd0);
`ifdef SPI_MISO_TRISTATE_EN
    check("rst_miso", 32'(spi_bus.MISO), 32'(1'bz));
`else
    check("rst_miso", 32'(spi_bus.MISO), 32'd0);
`endif
    rst = 1'b0;
    tick(4);

    for (int v = 0; v < 4; v++) begin
      clear_mon();
      if (vecs[v].queue) queue_send(vecs[v].send);
      frame_start();
      xfer_bits(vecs[v].mosi, 8, rd);
      frame_end();
      check("vec_rdy_count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("vec_rdy_value", 32'(rx_q[0]), 32'(vecs[v].exp_recv));
      check("vec_recv_hold", 32'(spi_bus.data_recv), 32'(vecs[v].exp_recv));
      check("vec_miso_read", 32'(rd), 32'(vecs[v].exp_miso));
      check("vec_bit_count", 32'(spi_bus.bit_count_out), 32'd0);
      check("vec_busy_end", 32'(spi_bus.busy), 32'd0);
      if (vecs[v].queue && rdy_busy_q.size() > 0 && post_busy_q.size() > 0) begin
        check("vec_busy_at_ready", 32'(rdy_busy_q[0]), 32'd1);
        check("vec_busy_after_ready", 32'(post_busy_q[0]), 32'd0);
      end
    end

    // three bytes in one frame
    clear_mon();
    frame_start();
    xfer_bits(8'h01, 8, r0);
    xfer_bits(8'h02, 8, r1);
    xfer_bits(8'h03, 8, r2);
    frame_end();
    check("b2b_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("b2b_byte0", 32'(rx_q[0]), 32'h01);
      check("b2b_byte1", 32'(rx_q[1]), 32'h02);
      check("b2b_byte2", 32'(rx_q[2]), 32'h03);
    end

    // queued byte followed by an unqueued byte in the same frame
    clear_mon();
    queue_send(8'hDE);
    frame_start();
    xfer_bits(8'h00, 8, r0);
    xfer_bits(8'h00, 8, r1);
    frame_end();
    check("tx_byte0", 32'(r0), 32'hDE);
    check("tx_byte1", 32'(r1), 32'h00);
    if (rdy_busy_q.size() > 1 && post_busy_q.size() > 0) begin
      check("tx_busy_at_ready", 32'(rdy_busy_q[0]), 32'd1);
      check("tx_busy_after_ready", 32'(post_busy_q[0]), 32'd0);
      check("tx_busy_second_ready", 32'(rdy_busy_q[1]), 32'd0);
    end else begin
      check("tx_ready_pulses", 32'(rdy_busy_q.size()), 32'd2);
    end

    // handshake: second byte queued in the gap between bytes, 0x55 ignored
    clear_mon();
    queue_send(8'hDE);
    spi_bus.data_send = 8'h55;
    spi_bus.do_send   = 1'b1;
    tick(1);
    spi_bus.do_send   = 1'b0;
    check("hs_busy_held", 32'(spi_bus.busy), 32'd1);
    fork
      begin
        frame_start();
        xfer_bits(8'h00, 8, r0);
        xfer_bits(8'h00, 8, r1);
        xfer_bits(8'h00, 8, r2);
        frame_end();
      end
      begin
        budget = 400;
        while (spi_bus.busy !== 1'b0 && budget > 0) begin
          tick(1);
          budget--;
        end
        check("hs_busy_clear_in_time", 32'(budget > 0), 32'd1);
        spi_bus.data_send = 8'hAD;
        spi_bus.do_send   = 1'b1;
        tick(1);
        spi_bus.do_send   = 1'b0;
      end
    join
    check("hs_byte0", 32'(r0), 32'hDE);
    check("hs_byte1", 32'(r1), 32'hAD);
    check("hs_byte2_no_55", 32'(r2), 32'h00);
    check("hs_busy_end", 32'(spi_bus.busy), 32'd0);

    // deselect after 5 bits
    clear_mon();
    queue_send(8'h99);
    frame_start();
    xfer_bits(8'hB6, 5, rd);
    check("abort_bit_count_mid", 32'(spi_bus.bit_count_out), 32'd5);
    check("abort_busy_mid", 32'(spi_bus.busy), 32'd1);
    check("abort_partial_miso", 32'(rd), 32'h98);
    frame_end();
    check("abort_no_ready", 32'(rx_q.size()), 32'd0);
    check("abort_bit_count", 32'(spi_bus.bit_count_out), 32'd0);
    check("abort_busy", 32'(spi_bus.busy), 32'd0);
    frame_start();
    xfer_bits(8'h3C, 8, rd);
    frame_end();
    check("abort_next_count", 32'(rx_q.size()), 32'd1);
    check("abort_next_recv", 32'(spi_bus.data_recv), 32'h3C);
    check("abort_next_miso", 32'(rd), 32'h00);

    // reset in the middle of a byte
    queue_send(8'h77);
    frame_start();
    xfer_bits(8'hE0, 3, rd);
    check("mid_bit_count", 32'(spi_bus.bit_count_out), 32'd3);
    check("mid_miso", 32'(spi_bus.MISO), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_data_ready", 32'(spi_bus.data_ready), 32'd0);
    check("arst_data_recv", 32'(spi_bus.data_recv), 32'd0);
    check("arst_bit_count", 32'(spi_bus.bit_count_out), 32'd0);
    check("arst_busy", 32'(spi_bus.busy), 32'd0);
`ifdef SPI_MISO_TRISTATE_EN
    check("arst_miso", 32'(spi_bus.MISO), 32'(1'bz));
`else
    check("arst_miso", 32'(spi_bus.MISO), 32'd0);
`endif
    spi_bus.SSEL = 1'b1;
    spi_bus.SCK  = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6);
    check("post_rst_busy", 32'(spi_bus.busy), 32'd0);
`ifdef SPI_MISO_TRISTATE_EN
    check("post_rst_miso_idle", 32'(spi_bus.MISO), 32'(1'bz));
`else
    check("post_rst_miso_idle", 32'(spi_bus.MISO), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
